// File: rtl/memory_arbiter.sv
// Round-robin memory arbiter: grants one CU at a time and forwards its address/enables to memory.
// Optional grant-hold watchdog enabled by defining ARB_WATCHDOG_EN.
module memory_arbiter #(
    parameter int unsigned num_cu          = 4,
    parameter int unsigned num_cu_log      = 2,
    parameter int unsigned memory_size_log = 10,
    parameter int unsigned max_hold        = 64
) (
    input  logic                                i_Clock,
    input  logic                                i_Reset_n,
    input  logic [num_cu-1:0]                   i_Grant_Request,
    input  logic [num_cu*memory_size_log-1:0]   i_Memory_Address,
    input  logic [num_cu-1:0]                   i_Memory_Write_Enable,
    input  logic [num_cu-1:0]                   i_Memory_Read_Enable,
    output logic [num_cu-1:0]                   o_Grant,
    output logic                                o_Grant_Valid,
    output logic [num_cu_log-1:0]               o_Grant_Index,
    output logic [memory_size_log-1:0]          o_Memory_Address,
    output logic                                o_Memory_Write_Enable,
    output logic                                o_Memory_Read_Enable,
    output logic                                o_Timeout
);

    typedef enum logic [1:0] {
        s_Idle,
        s_Granted,
        s_Release
    } state_t;

    // Elaboration guard: the grant index must be able to address every CU.
    if ((num_cu > (1 << num_cu_log)) || (max_hold == 0)) begin : g_bad_params
        $error("memory_arbiter: inconsistent num_cu/num_cu_log/max_hold");
    end

    state_t                  r_State;
    state_t                  w_Next_State;
    logic [num_cu_log-1:0]   r_Last_Granted;
    logic [num_cu_log-1:0]   w_Next_Last;
    logic [num_cu-1:0]       w_Next_Grant;
    logic                    w_Next_Valid;
    logic [num_cu_log-1:0]   w_Next_Index;
    logic [num_cu-1:0]       w_Eligible;
    logic [num_cu_log-1:0]   w_Candidate;
    logic [num_cu_log-1:0]   w_Winner;
    logic                    w_Found;

`ifdef ARB_WATCHDOG_EN
    localparam int unsigned CNT_W = $clog2(max_hold + 1);

    logic [CNT_W-1:0]        r_Hold_Count;
    logic [CNT_W-1:0]        w_Next_Count;
    logic [num_cu-1:0]       r_Mask;
    logic [num_cu-1:0]       w_Next_Mask;
    logic                    w_Next_Timeout;

    // A CU released by the watchdog stays ineligible until it drops its request.
    assign w_Eligible = i_Grant_Request & ~r_Mask;
`else
    assign w_Eligible = i_Grant_Request;
    assign o_Timeout  = 1'b0;
`endif

    // Round-robin search starting just after the last granted CU.
    always_comb begin
        w_Found     = 1'b0;
        w_Winner    = '0;
        w_Candidate = '0;
        for (int unsigned i = 0; i < num_cu; i++) begin
            w_Candidate = num_cu_log'((32'(r_Last_Granted) + 1 + i) % num_cu);
            if (!w_Found && w_Eligible[w_Candidate]) begin
                w_Found  = 1'b1;
                w_Winner = w_Candidate;
            end
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        w_Next_State = r_State;
        w_Next_Grant = o_Grant;
        w_Next_Valid = o_Grant_Valid;
        w_Next_Index = o_Grant_Index;
        w_Next_Last  = r_Last_Granted;
`ifdef ARB_WATCHDOG_EN
        w_Next_Count   = '0;
        w_Next_Mask    = r_Mask & i_Grant_Request;
        w_Next_Timeout = 1'b0;
`endif
        case (r_State)
            s_Idle: begin
                if (w_Found) begin
                    w_Next_State = s_Granted;
                    w_Next_Grant = num_cu'(1) << w_Winner;
                    w_Next_Valid = 1'b1;
                    w_Next_Index = w_Winner;
                    w_Next_Last  = w_Winner;
                end
            end
            s_Granted: begin
                if (!(|(i_Grant_Request & o_Grant))) begin
                    w_Next_State = s_Release;
                    w_Next_Grant = '0;
                    w_Next_Valid = 1'b0;
                    w_Next_Index = '0;
                end
`ifdef ARB_WATCHDOG_EN
                else if (r_Hold_Count == CNT_W'(max_hold - 1)) begin
                    w_Next_State   = s_Release;
                    w_Next_Grant   = '0;
                    w_Next_Valid   = 1'b0;
                    w_Next_Index   = '0;
                    w_Next_Timeout = 1'b1;
                    w_Next_Mask    = (r_Mask & i_Grant_Request) | o_Grant;
                end
                else begin
                    w_Next_Count = r_Hold_Count + CNT_W'(1);
                end
`endif
            end
            s_Release: begin
                w_Next_State = s_Idle;
            end
            default: begin
                w_Next_State = s_Idle;
                w_Next_Grant = '0;
                w_Next_Valid = 1'b0;
                w_Next_Index = '0;
            end
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge i_Clock) begin
        if (!i_Reset_n) begin
            r_State        <= s_Idle;
            o_Grant        <= '0;
            o_Grant_Valid  <= 1'b0;
            o_Grant_Index  <= '0;
            r_Last_Granted <= num_cu_log'(num_cu - 1);
        end else begin
            r_State        <= w_Next_State;
            o_Grant        <= w_Next_Grant;
            o_Grant_Valid  <= w_Next_Valid;
            o_Grant_Index  <= w_Next_Index;
            r_Last_Granted <= w_Next_Last;
        end
    end

`ifdef ARB_WATCHDOG_EN
    always_ff @(posedge i_Clock) begin
        if (!i_Reset_n) begin
            r_Hold_Count <= '0;
            r_Mask       <= '0;
            o_Timeout    <= 1'b0;
        end else begin
            r_Hold_Count <= w_Next_Count;
            r_Mask       <= w_Next_Mask;
            o_Timeout    <= w_Next_Timeout;
        end
    end
`endif

    // Memory-side mux: only the granted CU's signals pass through.
    always_comb begin
        o_Memory_Address      = '0;
        o_Memory_Write_Enable = 1'b0;
        o_Memory_Read_Enable  = 1'b0;
        for (int unsigned i = 0; i < num_cu; i++) begin
            if (o_Grant_Valid && o_Grant[i]) begin
                o_Memory_Address      = i_Memory_Address[i*memory_size_log +: memory_size_log];
                o_Memory_Write_Enable = i_Memory_Write_Enable[i];
                o_Memory_Read_Enable  = i_Memory_Read_Enable[i];
            end
        end
    end

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed testbench for memory_arbiter; covers the watchdog branch when ARB_WATCHDOG_EN is defined.
module tb_memory_arbiter;

    localparam int unsigned NUM_CU = 4;
    localparam int unsigned CU_LOG = 2;
    localparam int unsigned AW     = 10;

    logic                  i_Clock = 1'b0;
    logic                  i_Reset_n;
    logic [NUM_CU-1:0]     i_Grant_Request;
    logic [NUM_CU*AW-1:0]  i_Memory_Address;
    logic [NUM_CU-1:0]     i_Memory_Write_Enable;
    logic [NUM_CU-1:0]     i_Memory_Read_Enable;
    logic [NUM_CU-1:0]     o_Grant;
    logic                  o_Grant_Valid;
    logic [CU_LOG-1:0]     o_Grant_Index;
    logic [AW-1:0]         o_Memory_Address;
    logic                  o_Memory_Write_Enable;
    logic                  o_Memory_Read_Enable;
    logic                  o_Timeout;

    int n_compared   = 0;
    int n_mismatched = 0;

    memory_arbiter #(
        .num_cu          (NUM_CU),
        .num_cu_log      (CU_LOG),
        .memory_size_log (AW),
        .max_hold        (8)
    ) dut (
        .i_Clock               (i_Clock),
        .i_Reset_n             (i_Reset_n),
        .i_Grant_Request       (i_Grant_Request),
        .i_Memory_Address      (i_Memory_Address),
        .i_Memory_Write_Enable (i_Memory_Write_Enable),
        .i_Memory_Read_Enable  (i_Memory_Read_Enable),
        .o_Grant               (o_Grant),
        .o_Grant_Valid         (o_Grant_Valid),
        .o_Grant_Index         (o_Grant_Index),
        .o_Memory_Address      (o_Memory_Address),
        .o_Memory_Write_Enable (o_Memory_Write_Enable),
        .o_Memory_Read_Enable  (o_Memory_Read_Enable),
        .o_Timeout             (o_Timeout)
    );

    always #5 i_Clock = ~i_Clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_grant(input string tag, input logic [NUM_CU-1:0] exp_grant,
                               input logic [CU_LOG-1:0] exp_idx);
        check_eq({tag, ".grant"}, 32'(o_Grant), 32'(exp_grant));
        check_eq({tag, ".valid"}, 32'(o_Grant_Valid), 32'(exp_grant != '0));
        check_eq({tag, ".index"}, 32'(o_Grant_Index), 32'(exp_idx));
    endtask

    task automatic step();
        @(posedge i_Clock);
        #1;
    endtask

    task automatic do_reset();
        i_Reset_n = 1'b0;
        step();
        i_Reset_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        i_Reset_n             = 1'b0;
        i_Grant_Request       = '0;
        i_Memory_Address      = '0;
        i_Memory_Write_Enable = '0;
        i_Memory_Read_Enable  = '0;
        step();
        step();

        // Reset state
        check_grant("reset", 4'b0000, 2'd0);
        check_eq("reset.timeout", 32'(o_Timeout), 32'd0);
        check_eq("reset.mem_addr", 32'(o_Memory_Address), 32'd0);
        check_eq("reset.mem_we", 32'(o_Memory_Write_Enable), 32'd0);
        check_eq("reset.mem_re", 32'(o_Memory_Read_Enable), 32'd0);

        // Single CU0 access: granted at the first edge after reset, released after drop
        i_Reset_n       = 1'b1;
        i_Grant_Request = 4'b0001;
        step();
        check_grant("single.c1", 4'b0001, 2'd0);
        for (int c = 2; c <= 5; c++) begin
            step();
            check_grant("single.hold", 4'b0001, 2'd0);
        end
        i_Grant_Request = 4'b0000;
        step();
        check_grant("single.release", 4'b0000, 2'd0);
        step();
        check_grant("single.idle", 4'b0000, 2'd0);

        // All CUs requesting: round-robin 0,1,2,3,0
        do_reset();
        i_Grant_Request = 4'b1111;
        for (int n = 0; n < 5; n++) begin
            logic [CU_LOG-1:0] k;
            logic [NUM_CU-1:0] g;
            k = CU_LOG'(n % 4);
            g = NUM_CU'(1) << k;
            step();
            check_grant("rr.grant", g, k);
            step();
            check_grant("rr.hold1", g, k);
            step();
            check_grant("rr.hold2", g, k);
            i_Grant_Request = 4'b1111 & ~g;
            step();
            check_grant("rr.release", 4'b0000, 2'd0);
            i_Grant_Request = 4'b1111;
            step();
            check_grant("rr.dead", 4'b0000, 2'd0);
        end
        i_Grant_Request = 4'b0000;
        step();

        // Memory mux: only the granted CU2 reaches memory, CU1 is blocked
        i_Reset_n = 1'b0;
        i_Memory_Address[2*AW +: AW] = 10'h155;
        i_Memory_Read_Enable         = 4'b0100;
        i_Memory_Address[1*AW +: AW] = 10'h2AA;
        i_Memory_Write_Enable        = 4'b0010;
        step();
        check_eq("mux.nogrant_addr", 32'(o_Memory_Address), 32'd0);
        check_eq("mux.nogrant_we", 32'(o_Memory_Write_Enable), 32'd0);
        i_Reset_n       = 1'b1;
        i_Grant_Request = 4'b0100;
        step();
        check_grant("mux.grant", 4'b0100, 2'd2);
        i_Grant_Request = 4'b0110;
        step();
        check_grant("mux.hold", 4'b0100, 2'd2);
        check_eq("mux.addr", 32'(o_Memory_Address), 32'h155);
        check_eq("mux.we", 32'(o_Memory_Write_Enable), 32'd0);
        check_eq("mux.re", 32'(o_Memory_Read_Enable), 32'd1);
        i_Grant_Request = 4'b0000;
        step();
        step();
        i_Memory_Write_Enable = '0;
        i_Memory_Read_Enable  = '0;
        i_Memory_Address      = '0;

        // Reset in the middle of a CU3 grant
        do_reset();
        i_Grant_Request      = 4'b1000;
        i_Memory_Read_Enable = 4'b1000;
        step();
        check_grant("rst.cu3", 4'b1000, 2'd3);
        check_eq("rst.cu3_re", 32'(o_Memory_Read_Enable), 32'd1);
        i_Reset_n = 1'b0;
        step();
        check_grant("rst.dropped", 4'b0000, 2'd0);
        check_eq("rst.re_off", 32'(o_Memory_Read_Enable), 32'd0);
        i_Reset_n       = 1'b1;
        i_Grant_Request = 4'b1001;
        step();
        check_grant("rst.cu0_next", 4'b0001, 2'd0);
        i_Grant_Request      = 4'b0000;
        i_Memory_Read_Enable = '0;
        step();
        step();

        // CU0 holds its request for 20 cycles while CU1 waits
        do_reset();
        i_Grant_Request = 4'b0011;
`ifdef ARB_WATCHDOG_EN
        step();
        check_grant("wd.grant", 4'b0001, 2'd0);
        for (int c = 2; c <= 8; c++) begin
            step();
            check_grant("wd.hold", 4'b0001, 2'd0);
            check_eq("wd.no_timeout", 32'(o_Timeout), 32'd0);
        end
        step();
        check_grant("wd.forced_release", 4'b0000, 2'd0);
        check_eq("wd.timeout_pulse", 32'(o_Timeout), 32'd1);
        step();
        check_grant("wd.dead", 4'b0000, 2'd0);
        check_eq("wd.timeout_end", 32'(o_Timeout), 32'd0);
        step();
        check_grant("wd.cu1", 4'b0010, 2'd1);
        i_Grant_Request = 4'b0001;
        step();
        check_grant("wd.cu1_release", 4'b0000, 2'd0);
        step();
        check_grant("wd.idle", 4'b0000, 2'd0);
        step();
        check_grant("wd.cu0_masked", 4'b0000, 2'd0);
        i_Grant_Request = 4'b0000;
        step();
        check_grant("wd.cu0_drop", 4'b0000, 2'd0);
        i_Grant_Request = 4'b0001;
        step();
        check_grant("wd.cu0_regrant", 4'b0001, 2'd0);
`else
        for (int c = 1; c <= 20; c++) begin
            step();
            check_grant("nowd.hold", 4'b0001, 2'd0);
            check_eq("nowd.timeout", 32'(o_Timeout), 32'd0);
        end
`endif
        i_Grant_Request = 4'b0000;
        step();
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/memory_arbiter.md
MEMORY_ARBITER -- requirements
Module: memory_arbiter

Interface
REQ-001 Parameter num_cu, default 4, number of requesting CUs.
REQ-002 Parameter num_cu_log, default 2, width of the grant index.
REQ-003 Parameter memory_size_log, default 10, memory address width.
REQ-004 Parameter max_hold, default 64, watchdog grant-hold limit in cycles.
REQ-005 i_Clock  input  1  single clock; all state changes on its rising edge.
REQ-006 i_Reset_n  input  1  reset, synchronous, active-low.
REQ-007 i_Grant_Request  input  num_cu  per-CU request, held high for the whole access.
REQ-008 i_Memory_Address  input  num_cu*memory_size_log  packed per-CU addresses; CU n occupies bits [n*memory_size_log +: memory_size_log].
REQ-009 i_Memory_Write_Enable  input  num_cu  per-CU write enable.
REQ-010 i_Memory_Read_Enable  input  num_cu  per-CU read enable.
REQ-011 o_Grant  output  num_cu  one-hot grant, registered.
REQ-012 o_Grant_Valid  output  1  high when any grant is active.
REQ-013 o_Grant_Index  output  num_cu_log  index of granted CU; 0 when none.
REQ-014 o_Memory_Address  output  memory_size_log  address forwarded to memory.
REQ-015 o_Memory_Write_Enable  output  1  write enable forwarded to memory.
REQ-016 o_Memory_Read_Enable  output  1  read enable forwarded to memory.
REQ-017 o_Timeout  output  1  one-cycle pulse on watchdog forced release.

Function
REQ-018 FSM states SHALL be s_Idle, s_Granted, s_Release.
REQ-019 s_Idle: with any request high at an edge, SHALL grant the winner at that edge (grant visible next cycle) and enter s_Granted; else stay.
REQ-020 Winner SHALL be round-robin: first requesting CU searching from (r_Last_Granted+1) mod num_cu upward with wrap.
REQ-021 On grant, r_Last_Granted SHALL be set to the winner index.
REQ-022 s_Granted: while the granted CU's request stays high, o_Grant SHALL hold unchanged regardless of other requests.
REQ-023 s_Granted: granted request low at an edge -> o_Grant cleared, enter s_Release.
REQ-024 s_Release SHALL last exactly one cycle with no grant, then s_Idle; minimum request-to-next-grant gap is thus one dead cycle after release is seen.
REQ-025 o_Grant SHALL never have more than one bit set.
REQ-026 Memory outputs SHALL be combinational muxes of the granted CU's inputs when o_Grant_Valid=1, else address 0 and both enables 0.
REQ-027 Non-granted CUs' enables SHALL never reach the memory outputs.
REQ-028 Simultaneous requests from all CUs after reset SHALL be served in order 0,1,2,3,0,...
REQ-029 A request that drops before being granted SHALL be forgotten (no stored pending state).

Reset
REQ-030 i_Reset_n low at an edge SHALL force s_Idle, o_Grant=0, o_Grant_Valid=0, o_Grant_Index=0, o_Timeout=0, r_Last_Granted=num_cu-1, watchdog counter=0.
REQ-031 Reset mid-grant SHALL drop the grant at that edge; memory enables read 0 next cycle.
REQ-032 After reset deassertion the first arbitration SHALL occur at the next edge.

Configuration
REQ-033 Macro ARB_WATCHDOG_EN defined: counter counts cycles in s_Granted; when it reaches max_hold with request still high, SHALL clear the grant, pulse o_Timeout for one cycle, enter s_Release, and mask that CU until its request has been low for at least one edge.
REQ-034 ARB_WATCHDOG_EN undefined: no counter or mask logic, o_Timeout tied 0, grant held indefinitely per REQ-022.

Verification
REQ-035 Reset then request=4'b0001 at cycle 0 -> o_Grant=4'b0001, o_Grant_Index=0 at cycle 1; drop at cycle 5 -> o_Grant=0 at cycle 6.
REQ-036 Request=4'b1111 held, each CU drops for one cycle after 3 granted cycles -> grant order 0,1,2,3,0 with one dead cycle between grants.
REQ-037 CU2 granted with address 10'h155, read enable 1; CU1 drives write enable 1, address 10'h2AA -> memory sees 10'h155, write 0, read 1.
REQ-038 Reset low during CU3 grant -> o_Grant=0, o_Grant_Valid=0 next cycle; after release, request=4'b1001 -> CU0 granted.
REQ-039 ARB_WATCHDOG_EN, max_hold=8, CU0 holds request 20 cycles, CU1 requests -> o_Timeout pulses after 8 granted cycles, CU1 granted after dead cycle, CU0 not regranted until it drops.
REQ-040 ARB_WATCHDOG_EN undefined, same stimulus -> CU0 keeps grant all 20 cycles, o_Timeout stays 0.
